// File: rtl/bitwise_issue_pkg.sv
// Shared type and helper packages for the bitwise issue slice.
// types: machine word, instruction encoding, operand sizes, issue FSM states.
// instructions: opcode classification and operand-size helpers.

package types;

    typedef logic [63:0] long_t;

    typedef enum logic [1:0] {
        BITS_8  = 2'd0,
        BITS_16 = 2'd1,
        BITS_32 = 2'd2,
        BITS_64 = 2'd3
    } arg_size_t;

    typedef enum logic [4:0] {
        NOP    = 5'd0,
        ADD    = 5'd1,
        SUB    = 5'd2,
        MOV    = 5'd3,
        AND    = 5'd4,
        OR     = 5'd5,
        XOR    = 5'd6,
        NOT    = 5'd7,
        ROLR   = 5'd8,
        ROLL   = 5'd9,
        SHIFTR = 5'd10,
        SHIFTL = 5'd11,
        FLIP   = 5'd12
    } opcode_t;

    typedef logic [3:0] flags_t;

    localparam int USE_CARRY_BIT = 0;

    typedef struct packed {
        opcode_t   opcode;
        flags_t    flags;
        arg_size_t argSize0;
        long_t     arg0;
        long_t     arg1;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } bitwise_issue_state_t;

endpackage

package instructions;

    import types::*;

    function automatic logic is_bitwise_op(input opcode_t opcode);
        case (opcode)
            AND, OR, XOR, NOT, ROLR, ROLL, SHIFTR, SHIFTL, FLIP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Ops whose carry result may update the architectural carry flag
    function automatic logic is_carry_op(input opcode_t opcode);
        case (opcode)
            ROLR, ROLL, SHIFTR, SHIFTL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic long_t size_mask(input arg_size_t size);
        case (size)
            BITS_8:  return 64'h0000_0000_0000_00FF;
            BITS_16: return 64'h0000_0000_0000_FFFF;
            BITS_32: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [6:0] size_width(input arg_size_t size);
        case (size)
            BITS_8:  return 7'd8;
            BITS_16: return 7'd16;
            BITS_32: return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

endpackage

// File: rtl/bitwise_issue_bitwise.sv
// Combinational bitwise ALU unit. Operates at the operand width selected by
// argSize0; shifts fill with zero and report the last bit shifted out, rotates
// report the bit that wrapped last. A zero shift/rotate passes i_carry through.

module bitwise
    import types::*;
    import instructions::*;
(
    input  instruction_t instr,
    input  logic         i_carry,
    output long_t        result,
    output logic         o_carry
);

    long_t        mask;
    long_t        a;
    long_t        b;
    long_t        rotl;
    long_t        rotr;
    logic [6:0]   width;
    logic [5:0]   amt;
    logic [5:0]   rot;
    logic [127:0] ext;
    logic         unused_flags;

    assign unused_flags = ^instr.flags;

    // Evaluate the selected operation at the operand width
    always_comb begin
        mask    = size_mask(instr.argSize0);
        width   = size_width(instr.argSize0);
        a       = instr.arg0 & mask;
        b       = instr.arg1 & mask;
        amt     = instr.arg1[5:0];
        rot     = amt & 6'(width - 7'd1);
        rotl    = ((a << rot) | (a >> (width - 7'(rot)))) & mask;
        rotr    = ((a >> rot) | (a << (width - 7'(rot)))) & mask;
        ext     = '0;
        result  = '0;
        o_carry = i_carry;
        case (instr.opcode)
            AND:  result = a & b;
            OR:   result = a | b;
            XOR:  result = a ^ b;
            NOT:  result = ~a & mask;
            FLIP: result = (a ^ (64'd1 << amt)) & mask;
            SHIFTL: begin
                ext    = {64'd0, a} << amt;
                result = ext[63:0] & mask;
                if (amt != 6'd0) o_carry = ext[width];
            end
            SHIFTR: begin
                ext    = {a, 64'd0} >> amt;
                result = ext[127:64];
                if (amt != 6'd0) o_carry = ext[63];
            end
            ROLL: begin
                result = rotl;
                if (rot != 6'd0) o_carry = rotl[0];
            end
            ROLR: begin
                result = rotr;
                if (rot != 6'd0) o_carry = rotr[width - 7'd1];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_issue.sv
// Issue/collect sequencer for the bitwise ALU unit. Accepts one instruction,
// executes it for one cycle, then holds the tagged result until writeback
// takes it. Owns the architectural carry flag.
// Optional statistics counters: define BITWISE_ISSUE_STATS_EN.

module bitwise_issue
    import types::*;
    import instructions::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  instruction_t     in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output long_t            out_result,
    output logic             out_carry,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    input  logic             carry_wr_en,
    input  logic             carry_wr_data,
    output logic             carry_flag
`ifdef BITWISE_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_carry_sets
`endif
);

    bitwise_issue_state_t state;
    instruction_t         instr_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 carry_q;
    long_t                unit_result;
    logic                 unit_carry;
    logic                 op_valid;
    logic                 use_carry;
    logic                 carry_upd;

    bitwise u_bitwise (
        .instr   (instr_q),
        .i_carry (carry_q),
        .result  (unit_result),
        .o_carry (unit_carry)
    );

    assign op_valid   = is_bitwise_op(instr_q.opcode);
    assign use_carry  = instr_q.flags[USE_CARRY_BIT];
    assign carry_upd  = is_carry_op(instr_q.opcode) && use_carry;
    assign carry_flag = carry_q;

    // Issue FSM, output registers and architectural carry flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            instr_q    <= '0;
            tag_q      <= '0;
            carry_q    <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
            out_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        instr_q  <= in_instr;
                        tag_q    <= in_tag;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        out_result <= op_valid ? (unit_result & size_mask(instr_q.argSize0)) : '0;
                        out_carry  <= use_carry & unit_carry;
                        out_err    <= !op_valid;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        if (carry_upd) carry_q <= unit_carry;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
            // Context restore overrides any carry update made this cycle
            if (carry_wr_en) carry_q <= carry_wr_data;
        end
    end

`ifdef BITWISE_ISSUE_STATS_EN
    // Completed-op and carry-set counters; free-running, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops        <= '0;
            stat_carry_sets <= '0;
        end else begin
            if (state == DONE && out_ready && !flush)
                stat_ops <= stat_ops + 32'd1;
            if (state == EXEC && !flush && carry_upd && unit_carry && !carry_wr_en)
                stat_carry_sets <= stat_carry_sets + 32'd1;
        end
    end
`endif

endmodule
